// File: rtl/ex_stage_md.sv
// Execute stage: single-cycle ALU with operand forwarding, plus an iterative
// RV32M/RV64M multiply/divide unit that stalls the front of the pipeline.
module ex_stage_md #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic            flush,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic            alu_src,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [1:0]      forwardA,
    input  logic [1:0]      forwardB,
    input  logic [XLEN-1:0] ex_mem_alu_result,
    input  logic [XLEN-1:0] write_data,
    output logic [XLEN-1:0] alu_result,
    output logic            zero,
    output logic            out_valid,
    output logic            stall
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]   ONE_X    = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [2*XLEN-1:0] ONE_2X   = {{(2*XLEN-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_t;

    typedef enum logic [3:0] {
        A_ADD  = 4'd0,
        A_SUB  = 4'd1,
        A_SLL  = 4'd2,
        A_SLT  = 4'd3,
        A_SLTU = 4'd4,
        A_XOR  = 4'd5,
        A_SRL  = 4'd6,
        A_SRA  = 4'd7,
        A_OR   = 4'd8,
        A_AND  = 4'd9
    } alu_ctrl_t;

    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic s);
        if (s) neg_if = (~v) + ONE_X;
        else   neg_if = v;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_if_wide(input logic [2*XLEN-1:0] v, input logic s);
        if (s) neg_if_wide = (~v) + ONE_2X;
        else   neg_if_wide = v;
    endfunction

    state_t            state_r, state_n_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [XLEN-1:0]   hi_r, lo_r, b_r, res_r;
    logic [2:0]        funct3_r;
    logic              sa_r, sb_r;

    logic [XLEN-1:0]   fwd_a_s, fwd_b_s, op_b_s, alu_res_s;
    logic [CNT_W-1:0]  shamt_s;
    alu_ctrl_t         alu_ctrl_s;
    logic              is_m_s, sa_s, sb_s, launch_s, last_s, stall_s, out_valid_s;
    logic [XLEN:0]     mul_sum_s, div_shift_s, div_diff_s;
    logic [XLEN-1:0]   hi_nx_s, lo_nx_s, res_nx_s;
    logic [2*XLEN-1:0] prod_s;

    assign is_m_s  = (alu_op == 2'b10) && (funct7 == 7'b0000001);
    assign op_b_s  = alu_src ? imm : fwd_b_s;
    assign shamt_s = op_b_s[CNT_W-1:0];
    assign last_s  = (cnt_r == CNT_LAST);

    // Forwarding muxes for both operands
    always_comb begin
        case (forwardA)
            2'b10:   fwd_a_s = ex_mem_alu_result;
            2'b01:   fwd_a_s = write_data;
            default: fwd_a_s = rs1_data;
        endcase
        case (forwardB)
            2'b10:   fwd_b_s = ex_mem_alu_result;
            2'b01:   fwd_b_s = write_data;
            default: fwd_b_s = rs2_data;
        endcase
    end

    // ALU control decode from the main decoder class and function fields
    always_comb begin
        alu_ctrl_s = A_ADD;
        case (alu_op)
            2'b00: alu_ctrl_s = A_ADD;
            2'b01: alu_ctrl_s = A_SUB;
            2'b10, 2'b11: begin
                case (funct3)
                    3'b000:  alu_ctrl_s = (alu_op == 2'b10 && funct7[5]) ? A_SUB : A_ADD;
                    3'b001:  alu_ctrl_s = A_SLL;
                    3'b010:  alu_ctrl_s = A_SLT;
                    3'b011:  alu_ctrl_s = A_SLTU;
                    3'b100:  alu_ctrl_s = A_XOR;
                    3'b101:  alu_ctrl_s = funct7[5] ? A_SRA : A_SRL;
                    3'b110:  alu_ctrl_s = A_OR;
                    3'b111:  alu_ctrl_s = A_AND;
                    default: alu_ctrl_s = A_ADD;
                endcase
            end
            default: alu_ctrl_s = A_ADD;
        endcase
    end

    // Single-cycle ALU
    always_comb begin
        alu_res_s = {XLEN{1'b0}};
        case (alu_ctrl_s)
            A_ADD:   alu_res_s = fwd_a_s + op_b_s;
            A_SUB:   alu_res_s = fwd_a_s - op_b_s;
            A_SLL:   alu_res_s = fwd_a_s << shamt_s;
            A_SLT:   alu_res_s = {{(XLEN-1){1'b0}}, ($signed(fwd_a_s) < $signed(op_b_s))};
            A_SLTU:  alu_res_s = {{(XLEN-1){1'b0}}, (fwd_a_s < op_b_s)};
            A_XOR:   alu_res_s = fwd_a_s ^ op_b_s;
            A_SRL:   alu_res_s = fwd_a_s >> shamt_s;
            A_SRA:   alu_res_s = $signed(fwd_a_s) >>> shamt_s;
            A_OR:    alu_res_s = fwd_a_s | op_b_s;
            A_AND:   alu_res_s = fwd_a_s & op_b_s;
            default: alu_res_s = {XLEN{1'b0}};
        endcase
    end

    // Operand sign flags for the M operation being launched
    always_comb begin
        sa_s = 1'b0;
        sb_s = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                sa_s = fwd_a_s[XLEN-1];
                sb_s = op_b_s[XLEN-1];
            end
            3'b010: begin
                sa_s = fwd_a_s[XLEN-1];
                sb_s = 1'b0;
            end
            default: begin
                sa_s = 1'b0;
                sb_s = 1'b0;
            end
        endcase
    end

    // One shift-add or restoring-divide step on the magnitude registers
    always_comb begin
        mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_r} : {(XLEN+1){1'b0}});
        div_shift_s = {hi_r, lo_r[XLEN-1]};
        div_diff_s  = div_shift_s - {1'b0, b_r};
        if (funct3_r[2]) begin
            if (!div_diff_s[XLEN]) begin
                hi_nx_s = div_diff_s[XLEN-1:0];
                lo_nx_s = {lo_r[XLEN-2:0], 1'b1};
            end else begin
                hi_nx_s = div_shift_s[XLEN-1:0];
                lo_nx_s = {lo_r[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_nx_s = mul_sum_s[XLEN:1];
            lo_nx_s = {mul_sum_s[0], lo_r[XLEN-1:1]};
        end
    end

    // Sign correction of the final step; overflow falls out of the magnitude math
    always_comb begin
        prod_s = neg_if_wide({hi_nx_s, lo_nx_s}, sa_r ^ sb_r);
        if (funct3_r[2]) begin
            if (funct3_r[1]) begin
                res_nx_s = neg_if(hi_nx_s, sa_r);
            end else if (b_r == {XLEN{1'b0}}) begin
                res_nx_s = {XLEN{1'b1}};
            end else begin
                res_nx_s = neg_if(lo_nx_s, sa_r ^ sb_r);
            end
        end else if (funct3_r[1:0] == 2'b00) begin
            res_nx_s = prod_s[XLEN-1:0];
        end else begin
            res_nx_s = prod_s[2*XLEN-1:XLEN];
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_n_s   = state_r;
        stall_s     = 1'b0;
        out_valid_s = 1'b0;
        launch_s    = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (flush) begin
                    state_n_s = S_IDLE;
                end else if (in_valid && is_m_s) begin
                    launch_s  = 1'b1;
                    stall_s   = 1'b1;
                    state_n_s = S_BUSY;
                end else begin
                    out_valid_s = in_valid;
                end
            end
            S_BUSY: begin
                if (flush) begin
                    state_n_s = S_IDLE;
                end else begin
                    stall_s   = 1'b1;
                    state_n_s = last_s ? S_DONE : S_BUSY;
                end
            end
            S_DONE: begin
                state_n_s   = S_IDLE;
                out_valid_s = !flush;
            end
            default: state_n_s = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= S_IDLE;
        else     state_r <= state_n_s;
    end

    // Operand capture at launch, iteration in BUSY, result commit on the last step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r    <= {CNT_W{1'b0}};
            hi_r     <= {XLEN{1'b0}};
            lo_r     <= {XLEN{1'b0}};
            b_r      <= {XLEN{1'b0}};
            res_r    <= {XLEN{1'b0}};
            funct3_r <= 3'b000;
            sa_r     <= 1'b0;
            sb_r     <= 1'b0;
        end else if (launch_s) begin
            cnt_r    <= {CNT_W{1'b0}};
            hi_r     <= {XLEN{1'b0}};
            lo_r     <= neg_if(fwd_a_s, sa_s);
            b_r      <= neg_if(op_b_s, sb_s);
            funct3_r <= funct3;
            sa_r     <= sa_s;
            sb_r     <= sb_s;
        end else if (state_r == S_BUSY) begin
            cnt_r <= cnt_r + CNT_ONE;
            hi_r  <= hi_nx_s;
            lo_r  <= lo_nx_s;
            if (last_s && !flush) res_r <= res_nx_s;
        end
    end

    assign alu_result = (state_r == S_DONE) ? res_r : alu_res_s;
    assign zero       = (alu_result == {XLEN{1'b0}});
    assign stall      = stall_s & ~rst;
    assign out_valid  = out_valid_s & ~rst;

endmodule
